// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction fetch/sequencing stage for picoMips.
// Drives the address of the synchronous program memory and hides its one-cycle read latency.
// It runs the halt-until-switch opcode (HEI) locally against a synchronised, debounced SW8,
// and forwards every other instruction to decode with a one-cycle valid strobe.
// The program counter wraps at PROG_LEN.
//
// Ports:
//   Clock        in   system clock, rising edge
//   nReset       in   asynchronous active-low reset
//   Sw8          in   raw asynchronous switch SW8
//   Instruction  in   program memory read data (word at the previous cycle's Addr)
//   Addr         out  program memory address (registered)
//   Exec_Instr   out  instruction forwarded to decode (registered)
//   Exec_Valid   out  one-cycle strobe: Exec_Instr holds a new non-HEI instruction
//   Waiting      out  sequencer is stalled in an HEI wait (registered)
module fetch_sequencer #(
  parameter int unsigned ADDR_W          = 5,
  parameter int unsigned PROG_LEN        = 28,
  parameter logic [5:0]  OP_HEI          = 6'b000000,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic              Clock,
  input  logic              nReset,
  input  logic              Sw8,
  input  logic [9:0]        Instruction,
  output logic [ADDR_W-1:0] Addr,
  output logic [9:0]        Exec_Instr,
  output logic              Exec_Valid,
  output logic              Waiting
);

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(PROG_LEN - 1);
  localparam int unsigned       CntW     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0]   CntMax   = CntW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {StFill, StRun, StWait} state_e;

  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    return (a == LastAddr) ? '0 : a + ADDR_W'(1);
  endfunction

  // ---------------------------------------------------------------------------
  // SW8 synchroniser and debouncer
  // ---------------------------------------------------------------------------
  logic            sync1_q, sync2_q;
  logic            db_q, db_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      db_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= Sw8;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
    end
  end

  // cnt_q counts mismatch cycles already seen; the flip happens on the
  // DEBOUNCE_CYCLES-th consecutive mismatching cycle.
  always_comb begin
    db_d  = db_q;
    cnt_d = cnt_q;
    if (sync2_q == db_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntMax) begin
      db_d  = sync2_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Fetch sequencer FSM
  // ---------------------------------------------------------------------------
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [9:0]        exec_instr_q, exec_instr_d;
  logic              exec_valid_q, exec_valid_d;
  logic              waiting_q, waiting_d;
  logic              wait_bit_q, wait_bit_d;

  logic is_hei;
  assign is_hei = (Instruction[9:4] == OP_HEI);

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q      <= StFill;
      addr_q       <= '0;
      exec_instr_q <= '0;
      exec_valid_q <= 1'b0;
      waiting_q    <= 1'b0;
      wait_bit_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      exec_instr_q <= exec_instr_d;
      exec_valid_q <= exec_valid_d;
      waiting_q    <= waiting_d;
      wait_bit_q   <= wait_bit_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    exec_instr_d = exec_instr_q;
    exec_valid_d = 1'b0;
    waiting_d    = waiting_q;
    wait_bit_d   = wait_bit_q;

    unique case (state_q)
      // Memory output is stale after reset; just issue the second address.
      StFill: begin
        addr_d  = next_addr(addr_q);
        state_d = StRun;
      end

      StRun: begin
        if (!is_hei) begin
          exec_instr_d = Instruction;
          exec_valid_d = 1'b1;
          addr_d       = next_addr(addr_q);
        end else if (db_q != Instruction[0]) begin
          // Condition already met: HEI degenerates to a skip.
          addr_d = next_addr(addr_q);
        end else begin
          // Hold Addr so memory keeps presenting the word after the HEI.
          wait_bit_d = Instruction[0];
          waiting_d  = 1'b1;
          state_d    = StWait;
        end
      end

      StWait: begin
        if (db_q != wait_bit_q) begin
          waiting_d = 1'b0;
          addr_d    = next_addr(addr_q);
          state_d   = StRun;
        end
      end

      default: begin
        state_d = StFill;
      end
    endcase
  end

  assign Addr       = addr_q;
  assign Exec_Instr = exec_instr_q;
  assign Exec_Valid = exec_valid_q;
  assign Waiting    = waiting_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: synchronous memory model, a program-level
// reference model compared every cycle, plus directed scenarios with literal expectations.
module tb_fetch_sequencer;

  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned PROG_LEN = 28;
  localparam int unsigned DB       = 4;
  localparam logic [5:0]  OP_HEI   = 6'b000000;

  logic              Clock  = 1'b0;
  logic              nReset = 1'b0;
  logic              Sw8    = 1'b0;
  logic [9:0]        Instruction;
  logic [ADDR_W-1:0] Addr;
  logic [9:0]        Exec_Instr;
  logic              Exec_Valid;
  logic              Waiting;

  logic [9:0] mem [0:31];

  int checks = 0;
  int errors = 0;

  fetch_sequencer #(
    .ADDR_W          (ADDR_W),
    .PROG_LEN        (PROG_LEN),
    .OP_HEI          (OP_HEI),
    .DEBOUNCE_CYCLES (DB)
  ) dut (
    .Clock       (Clock),
    .nReset      (nReset),
    .Sw8         (Sw8),
    .Instruction (Instruction),
    .Addr        (Addr),
    .Exec_Instr  (Exec_Instr),
    .Exec_Valid  (Exec_Valid),
    .Waiting     (Waiting)
  );

  always #5 Clock = ~Clock;

  // Synchronous program memory: one-cycle read latency.
  initial Instruction = '0;
  always @(posedge Clock) Instruction <= mem[Addr];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int nxt(input int a);
    return (a == PROG_LEN - 1) ? 0 : a + 1;
  endfunction

  function automatic bit is_hei(input logic [9:0] w);
    return w[9:4] == OP_HEI;
  endfunction

  // ---------------------------------------------------------------------------
  // Reference model, program level: m_pc is the index of the next word to be consumed.
  // The switch is a 2-sample delay line followed by "flip once the last DB samples all
  // disagree with the debounced value".
  // ---------------------------------------------------------------------------
  bit         m_started = 0;
  bit         m_wait    = 0;
  bit         m_wbit    = 0;
  bit         m_db      = 0;
  bit         m_raw1    = 0;
  bit         m_raw2    = 0;
  bit [DB-1:0] m_hist   = '0;
  int         m_pc      = 0;
  logic [9:0] m_instr   = '0;
  bit         m_valid   = 0;
  bit         mdl_s;
  bit         mdl_db_old;
  logic [9:0] mdl_w;

  always @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      m_started = 0; m_wait = 0; m_wbit = 0; m_db = 0;
      m_raw1 = 0; m_raw2 = 0; m_hist = '0;
      m_pc = 0; m_instr = '0; m_valid = 0;
    end else begin
      mdl_db_old = m_db;
      m_valid    = 0;
      if (!m_started) begin
        m_started = 1;
      end else if (m_wait) begin
        if (mdl_db_old != m_wbit) m_wait = 0;
      end else begin
        mdl_w = mem[m_pc];
        if (!is_hei(mdl_w)) begin
          m_instr = mdl_w;
          m_valid = 1;
        end else if (mdl_db_old == mdl_w[0]) begin
          m_wait = 1;
          m_wbit = mdl_w[0];
        end
        m_pc = nxt(m_pc);
      end
      mdl_s  = m_raw2;
      m_raw2 = m_raw1;
      m_raw1 = Sw8;
      m_hist = {m_hist[DB-2:0], mdl_s};
      if (m_hist == {DB{~m_db}}) m_db = ~m_db;
    end
  end

  function automatic int exp_addr();
    if (!m_started) return 0;
    return m_wait ? m_pc : nxt(m_pc);
  endfunction

  // Compare process: every output, every cycle.
  always @(negedge Clock) begin
    check("addr", int'(Addr), exp_addr());
    check("exec_valid", int'(Exec_Valid), int'(m_valid));
    check("exec_instr", int'(Exec_Instr), int'(m_instr));
    check("waiting", int'(Waiting), int'(m_wait));
    if (Exec_Valid) check("hei_not_forwarded", int'(Exec_Instr[9:4] == OP_HEI), 0);
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic cyc(input int n);
    repeat (n) @(negedge Clock);
  endtask

  task automatic fill_mem(input int hei_pct);
    for (int i = 0; i < 32; i++) begin
      if (int'($urandom_range(0, 99)) < hei_pct) mem[i] = {OP_HEI, 4'($urandom)};
      else mem[i] = {6'($urandom_range(1, 63)), 4'($urandom)};
    end
  endtask

  // Asynchronous assert mid-cycle; returns at a negedge still in reset.
  task automatic do_reset();
    @(posedge Clock);
    #2 nReset = 1'b0;
    #1;
    check("async_rst_addr", int'(Addr), 0);
    check("async_rst_valid", int'(Exec_Valid), 0);
    check("async_rst_waiting", int'(Waiting), 0);
    check("async_rst_instr", int'(Exec_Instr), 0);
    @(negedge Clock);
  endtask

  // Count cycles until Waiting reads the given value (bounded).
  task automatic cycles_until_waiting(input bit val, input int limit, output int n);
    n = 0;
    while (Waiting != val && n < limit) begin
      cyc(1);
      n++;
    end
  endtask

  int n;
  int cnt_a, cnt_b;
  int prev_addr;

  initial begin
    // ---- Reset and fill, sustained throughput and wrap ----
    fill_mem(0);
    cyc(1);
    check("rst_addr", int'(Addr), 0);
    check("rst_valid", int'(Exec_Valid), 0);
    check("rst_waiting", int'(Waiting), 0);
    check("rst_instr", int'(Exec_Instr), 0);
    nReset = 1'b1;
    cyc(1);
    check("edge1_addr", int'(Addr), 1);
    check("edge1_valid", int'(Exec_Valid), 0);
    for (int k = 0; k < 45; k++) begin
      cyc(1);
      check("stream_valid", int'(Exec_Valid), 1);
      check("stream_instr", int'(Exec_Instr), int'(mem[k % PROG_LEN]));
      check("stream_addr", int'(Addr), (k + 2) % PROG_LEN);
    end

    // ---- Skip HEI: sw8_db already 1 when HEI 0 at address 5 arrives ----
    do_reset();
    Sw8 = 1'b1;
    fill_mem(0);
    mem[5] = 10'b000000_1110;
    nReset = 1'b1;
    cyc(2);
    cnt_a = 0; cnt_b = 0;
    prev_addr = int'(Addr);
    for (int k = 0; k < 60; k++) begin
      if (!Exec_Valid) cnt_a++;
      if (Waiting) cnt_b++;
      cyc(1);
      check("skip_addr_advances", int'(Addr == ADDR_W'(prev_addr)), 0);
      prev_addr = int'(Addr);
    end
    check("skip_bubbles", cnt_a, 2);
    check("skip_never_waits", cnt_b, 0);

    // ---- Stall HEI 0 at address 0, release after 20 cycles ----
    do_reset();
    Sw8 = 1'b0;
    fill_mem(0);
    mem[0] = 10'b000000_0000;
    nReset = 1'b1;
    cyc(20);
    check("stall_waiting", int'(Waiting), 1);
    check("stall_addr_held", int'(Addr), 1);
    Sw8 = 1'b1;
    cycles_until_waiting(1'b0, 30, n);
    check("stall_exit_latency", n, 3 + DB);
    n = 0;
    while (!Exec_Valid && n < 10) begin
      cyc(1);
      n++;
    end
    check("stall_next_latency", n, 1);
    check("stall_next_word", int'(Exec_Instr), int'(mem[1]));

    // ---- Reset mid-wait, then restart from word 0 ----
    do_reset();
    Sw8 = 1'b0;
    nReset = 1'b1;
    cyc(10);
    check("midwait_waiting", int'(Waiting), 1);
    do_reset();
    mem[0] = 10'b101010_0101;
    nReset = 1'b1;
    cyc(1);
    check("restart_addr", int'(Addr), 1);
    cyc(1);
    check("restart_valid", int'(Exec_Valid), 1);
    check("restart_word0", int'(Exec_Instr), int'(mem[0]));

    // ---- Debounce: HEI 1 at address 10, 3-cycle low glitch, then sustained low ----
    do_reset();
    Sw8 = 1'b1;
    fill_mem(0);
    mem[10] = 10'b000000_0001;
    nReset = 1'b1;
    cycles_until_waiting(1'b1, 40, n);
    check("db_enter_wait", int'(Waiting), 1);
    cyc(5);
    Sw8 = 1'b0;
    cyc(3);
    Sw8 = 1'b1;
    cyc(12);
    check("db_glitch_ignored", int'(Waiting), 1);
    check("db_addr_held", int'(Addr), 11);
    Sw8 = 1'b0;
    cycles_until_waiting(1'b0, 30, n);
    check("db_exit_latency", n, 3 + DB);

    // ---- Back-to-back HEI 0 then HEI 1 at addresses 3 and 4 ----
    do_reset();
    Sw8 = 1'b0;
    fill_mem(0);
    mem[3] = 10'b000000_0110;
    mem[4] = 10'b000000_1001;
    nReset = 1'b1;
    cycles_until_waiting(1'b1, 30, n);
    check("b2b_first_wait", int'(Waiting), 1);
    check("b2b_first_addr", int'(Addr), 4);
    cyc(5);
    Sw8 = 1'b1;
    cycles_until_waiting(1'b0, 30, n);
    check("b2b_first_exit", n, 3 + DB);
    cyc(1);
    check("b2b_second_wait", int'(Waiting), 1);
    check("b2b_second_addr", int'(Addr), 5);
    cyc(5);
    Sw8 = 1'b0;
    cycles_until_waiting(1'b0, 30, n);
    check("b2b_second_exit", n, 3 + DB);
    cyc(1);
    check("b2b_resume_valid", int'(Exec_Valid), 1);
    check("b2b_resume_word", int'(Exec_Instr), int'(mem[5]));

    // ---- Randomised programs and switch activity against the model ----
    for (int r = 0; r < 4; r++) begin
      do_reset();
      fill_mem(15);
      Sw8 = 1'($urandom);
      nReset = 1'b1;
      for (int k = 0; k < 700; k++) begin
        cyc(1);
        if ($urandom_range(0, 11) == 0) Sw8 = ~Sw8;
      end
    end

    cyc(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
